sync_fifo_v2: RTL
=================

Name: sync_fifo_v2

Overview:
- Single-clock, parametrised synchronous FIFO; next generation of the PE-side buffering FIFO.
- Adds the following over the existing FIFO:
  - selectable first-word-fall-through (FWFT) or registered-read mode;
  - true fill count;
  - runtime-programmable almost-full and almost-empty thresholds;
  - guarded push and pop;
  - sticky overflow and underflow error flags.
- Sits between PE datapath producers and consumers wherever occupancy-based back-pressure is needed.

Parameters:
- DEPTH_WIDTH, 4, log2 of entry count; depth = 2**DEPTH_WIDTH; values below 1 are clamped to 1.
- DATA_WIDTH, 16, word width in bits; values below 1 are clamped to 1.
- FWFT, 1, 1 = head word is presented combinationally on rd_data_o; 0 = registered read with rd_valid_o.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- wr_data_i  in  DATA_WIDTH  write data.
- wr_en_i  in  1  push request.
- rd_en_i  in  1  pop request.
- rd_data_o  out  DATA_WIDTH  read data.
- rd_valid_o  out  1  FWFT=0: pulses one cycle with returned data; FWFT=1: equals !empty_o.
- full_o  out  1  count == depth.
- empty_o  out  1  count == 0.
- count_o  out  DEPTH_WIDTH+1  current occupancy, 0..depth.
- afull_thresh_i  in  DEPTH_WIDTH+1  almost-full threshold.
- aempty_thresh_i  in  DEPTH_WIDTH+1  almost-empty threshold.
- almost_full_o  out  1  count_o >= afull_thresh_i.
- almost_empty_o  out  1  count_o <= aempty_thresh_i.
- overflow_o  out  1  sticky: a push was attempted while full.
- underflow_o  out  1  sticky: a pop was attempted while empty.
- clr_err_i  in  1  synchronous clear of both sticky error flags.

Behaviour:
- Reset (asynchronous on rst_n low):
  - wptr, rptr, count, rd_data_o register, rd_valid_o, overflow_o and underflow_o all go to 0.
  - Outputs after reset: empty_o=1, full_o=0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all contents; the first push after reset release is accepted normally.
- Pointers:
  - wptr and rptr are DEPTH_WIDTH bits wide and wrap naturally modulo depth.
  - count is a separate (DEPTH_WIDTH+1)-bit register.
- Push accept: push_ok = wr_en_i & !full_o. On an accepted push, mem[wptr] <= wr_data_i and wptr++.
- Pop accept: pop_ok = rd_en_i & !empty_o. On an accepted pop, rptr++.
- Count update: count += push_ok - pop_ok.
  - Simultaneous accepted push and pop leaves count unchanged.
- Flags use pre-edge state:
  - When full, a simultaneous push and pop accepts only the pop; the push is lost and sets overflow_o.
  - When empty, a simultaneous push and pop accepts only the push; the pop sets underflow_o.
  - There is no same-address bypass.
- Errors:
  - overflow_o is set on the edge where wr_en_i & full_o.
  - underflow_o is set on the edge where rd_en_i & empty_o.
  - clr_err_i clears both flags; if a set condition occurs in the same cycle as clr_err_i, set wins.
- FWFT=1:
  - rd_data_o = mem[rptr] combinationally, valid whenever empty_o=0.
  - A word pushed at edge N is visible on rd_data_o in the cycle after edge N.
  - Popping at edge M makes the next word visible after edge M.
- FWFT=0:
  - On pop_ok, rd_data_o <= mem[rptr] and rd_valid_o <= 1; otherwise rd_valid_o <= 0.
  - rd_data_o holds its value when no pop occurs.
  - Latency from pop to data is 1 cycle.
- Status outputs:
  - full_o, empty_o, almost_full_o and almost_empty_o are combinational from the count register and the threshold inputs. They are glitch-free relative to clk.
  - Threshold changes take effect in the same cycle.
  - afull_thresh_i=0 forces almost_full_o=1.
  - aempty_thresh_i >= depth forces almost_empty_o=1.

Decomposition:
- Shared package fifo_pkg, containing:
  - default DATA_WIDTH and DEPTH_WIDTH;
  - the FWFT/registered mode constants;
  - a clamp-to-1 width function used for the localparam widths.
- One sub-module, fifo_regfile: 2**AW x DW register array with one write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- Control logic, flags and the output register stay in sync_fifo_v2.

Test Plan (DEPTH_WIDTH=2, depth 4; DATA_WIDTH=8):
- Reset: assert rst_n=0 asynchronously mid-clock after 3 pushes -> immediately count_o=0, empty_o=1, full_o=0, overflow_o=0. The next push of 0x5A is read back as 0x5A.
- FWFT=1, fill/drain: push 0x11, 0x22, 0x33, 0x44.
  - After the 4th edge: full_o=1, count_o=4.
  - rd_data_o=0x11 from the cycle after the first push.
  - Pops return 0x11 through 0x44 in order, then empty_o=1.
- FWFT=0: push 0xA1, 0xB2, then pop twice -> rd_valid_o pulses on the two edges after each pop with 0xA1 then 0xB2, and rd_valid_o=0 between pulses.
- Boundaries: while full, wr_en_i=rd_en_i=1 -> count_o goes 4->3 and overflow_o=1. While empty, both enables high -> count_o goes 0->1 and underflow_o=1. clr_err_i clears both flags.
- Thresholds:
  - afull=3, aempty=1: almost_full_o rises at count 3; almost_empty_o is 1 at counts 0..1 and 0 at count 2.
  - Change afull to 0 -> almost_full_o=1 in the same cycle.
- Wrap-around: 10 pushes interleaved with 10 pops of an incrementing pattern 0x00..0x09 with the FIFO never empty -> data returned in order, no error flags set, and count_o never exceeds 4.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the PE-side synchronous FIFO family.
//   DEF_DATA_WIDTH / DEF_DEPTH_WIDTH : default word width and log2 depth
//   MODE_REGISTERED / MODE_FWFT      : values for the FWFT parameter
//   clamp_w()                        : forces a width parameter to at least 1
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 16;
  localparam int unsigned DEF_DEPTH_WIDTH = 4;

  localparam int unsigned MODE_REGISTERED = 0;
  localparam int unsigned MODE_FWFT       = 1;

  function automatic int unsigned clamp_w(input int w);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// 2**AW x DW storage array: one synchronous write port, one asynchronous
// read port. Contents are not reset.
//   clk          : clock, rising edge
//   we/waddr/wdata : write port
//   raddr/rdata  : combinational read port
module fifo_regfile #(
  parameter int unsigned AW = 2,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_v2.sv
// Single-clock parametrised FIFO with FWFT or registered read, fill count,
// programmable almost-full/almost-empty thresholds, guarded push/pop and
// sticky overflow/underflow flags.
//   clk, rst_n               : clock (rising), async active-low reset
//   wr_data_i, wr_en_i       : push data / request
//   rd_en_i                  : pop request
//   rd_data_o, rd_valid_o    : read data and its qualifier
//   full_o, empty_o, count_o : occupancy status
//   afull_thresh_i, aempty_thresh_i, almost_full_o, almost_empty_o
//   overflow_o, underflow_o, clr_err_i : sticky error flags and their clear
module sync_fifo_v2
  import fifo_pkg::*;
#(
  parameter int          DEPTH_WIDTH = DEF_DEPTH_WIDTH,
  parameter int          DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned FWFT        = MODE_FWFT
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [clamp_w(DATA_WIDTH)-1:0]     wr_data_i,
  input  logic                               wr_en_i,
  input  logic                               rd_en_i,
  output logic [clamp_w(DATA_WIDTH)-1:0]     rd_data_o,
  output logic                               rd_valid_o,
  output logic                               full_o,
  output logic                               empty_o,
  output logic [clamp_w(DEPTH_WIDTH):0]      count_o,
  input  logic [clamp_w(DEPTH_WIDTH):0]      afull_thresh_i,
  input  logic [clamp_w(DEPTH_WIDTH):0]      aempty_thresh_i,
  output logic                               almost_full_o,
  output logic                               almost_empty_o,
  output logic                               overflow_o,
  output logic                               underflow_o,
  input  logic                               clr_err_i
);

  localparam int unsigned AW = clamp_w(DEPTH_WIDTH);
  localparam int unsigned DW = clamp_w(DATA_WIDTH);
  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;
  logic [DW-1:0] head;
  logic          ovf_q;
  logic          unf_q;

  // Status is decoded from the count register only, so it is glitch-free
  // with respect to clk; thresholds act combinationally.
  assign full           = (count == DEPTH_C);
  assign empty          = (count == '0);
  assign full_o         = full;
  assign empty_o        = empty;
  assign count_o        = count;
  assign almost_full_o  = (count >= afull_thresh_i);
  assign almost_empty_o = (count <= aempty_thresh_i);
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

  assign push_ok = wr_en_i & ~full;
  assign pop_ok  = rd_en_i & ~empty;

  fifo_regfile #(
    .AW (AW),
    .DW (DW)
  ) u_regfile (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wptr),
    .wdata (wr_data_i),
    .raddr (rptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A set condition in the same cycle as clr_err_i wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_en_i & full)  ovf_q <= 1'b1;
      else if (clr_err_i)  ovf_q <= 1'b0;
      if (rd_en_i & empty) unf_q <= 1'b1;
      else if (clr_err_i)  unf_q <= 1'b0;
    end
  end

  if (FWFT != MODE_REGISTERED) begin : g_fwft
    assign rd_data_o  = head;
    assign rd_valid_o = ~empty;
  end else begin : g_reg
    logic [DW-1:0] rd_q;
    logic          rd_v_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q   <= '0;
        rd_v_q <= 1'b0;
      end else begin
        if (pop_ok) rd_q <= head;
        rd_v_q <= pop_ok;
      end
    end

    assign rd_data_o  = rd_q;
    assign rd_valid_o = rd_v_q;
  end

endmodule
